// File: rtl/shift_tx_pkg.sv
// rtl/shift_tx_pkg.sv - shared constants and state encoding for the serial transmit controller
package shift_tx_pkg;

    localparam int DATA_BITS = 8;
    localparam int CNT_W     = 16;
    localparam int IDX_W     = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

endpackage

// File: rtl/shift_tx_ctrl_bit_timer.sv
// rtl/shift_tx_ctrl_bit_timer.sv - bit-period counter with last-cycle-of-period flag
module bit_timer
    import shift_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_load,
    input  logic i_enable,
    output logic o_last
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    // Count cycles within a bit period; load returns the count to zero, the
    // final cycle of a period wraps so the next period starts cleanly.
    always_ff @(posedge clock) begin
        if (!reset_n || i_load) begin
            r_count <= '0;
        end else if (i_enable) begin
            if (o_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_last = (r_count == LAST_COUNT);

endmodule

// File: rtl/shift_tx_ctrl.sv
// rtl/shift_tx_ctrl.sv - serial transmit controller driving an external 8-bit shift register
module shift_tx_ctrl
    import shift_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [7:0] load_val,
    output logic       load_n,
    output logic       shift_right,
    output logic       asr,
    input  logic       q_lsb,
    output logic       tx_bit,
    output logic       busy,
    output logic       done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic [2:0]       r_state;
    logic [IDX_W-1:0] r_bit_idx;
    logic [7:0]       r_load_val;

    logic w_last;
    logic w_timer_load;
    logic w_timer_en;

    // The period counter is held at zero until the line starts toggling, so
    // the START bit always gets a full period.
    assign w_timer_load = (r_state == ST_IDLE) || (r_state == ST_LOAD);
    assign w_timer_en   = !w_timer_load;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .i_load  (w_timer_load),
        .i_enable(w_timer_en),
        .o_last  (w_last)
    );

    // Frame sequencing: IDLE -> LOAD -> START -> DATA x8 -> STOP -> IDLE.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_bit_idx  <= '0;
            r_load_val <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (data_valid) begin
                        r_load_val <= data_in;
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_START;
                end
                ST_START: begin
                    if (w_last) begin
                        r_state   <= ST_DATA;
                        r_bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_last) begin
                        if (r_bit_idx == LAST_IDX) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_ready  = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign load_val    = r_load_val;
    assign load_n      = (r_state != ST_LOAD);
    assign shift_right = (r_state == ST_DATA) && w_last;
    assign done        = (r_state == ST_STOP) && w_last;
    assign asr         = 1'b0;

    // Serial line level: start bit low, data straight from the shift register, otherwise idle high.
    always_comb begin
        tx_bit = 1'b1;
        case (r_state)
            ST_START: tx_bit = 1'b0;
            ST_DATA:  tx_bit = q_lsb;
            default:  tx_bit = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// tb/tb_shift_tx_ctrl.sv - scoreboard bench for shift_tx_ctrl at CLKS_PER_BIT 4 and 1
module tb_shift_tx_ctrl;

    localparam int CPB0 = 4;
    localparam int CPB1 = 1;

    logic       clock = 1'b0;
    logic       rstn     [2];
    logic       valid    [2];
    logic [7:0] din      [2];
    logic       ready_o  [2];
    logic       busy_o   [2];
    logic       tx_o     [2];
    logic       ldn_o    [2];
    logic       sh_o     [2];
    logic       asr_o    [2];
    logic       done_o   [2];
    logic [7:0] lval_o   [2];
    logic [7:0] sr       [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_on   = 1'b0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    bit         in_frame [2];
    int         pos      [2];
    int         shifts   [2];
    logic [7:0] cur      [2];
    logic [7:0] last_b   [2];

    int mcpb, mflen, mp, mq, mr;
    logic e_tx, e_sh;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    shift_tx_ctrl #(.CLKS_PER_BIT(CPB0)) dut0 (
        .clock(clock), .reset_n(rstn[0]), .data_in(din[0]), .data_valid(valid[0]),
        .data_ready(ready_o[0]), .load_val(lval_o[0]), .load_n(ldn_o[0]),
        .shift_right(sh_o[0]), .asr(asr_o[0]), .q_lsb(sr[0][0]), .tx_bit(tx_o[0]),
        .busy(busy_o[0]), .done(done_o[0])
    );

    shift_tx_ctrl #(.CLKS_PER_BIT(CPB1)) dut1 (
        .clock(clock), .reset_n(rstn[1]), .data_in(din[1]), .data_valid(valid[1]),
        .data_ready(ready_o[1]), .load_val(lval_o[1]), .load_n(ldn_o[1]),
        .shift_right(sh_o[1]), .asr(asr_o[1]), .q_lsb(sr[1][0]), .tx_bit(tx_o[1]),
        .busy(busy_o[1]), .done(done_o[1])
    );

    // Downstream shift register: parallel load or logical right shift.
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (!ldn_o[i]) sr[i] <= lval_o[i];
            else if (sh_o[i]) sr[i] <= {1'b0, sr[i][7:1]};
        end
    end

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, i, cyc, act, exp);
        end
    endtask

    // Monitor: frame-position model, pops the scoreboard at each frame's load cycle.
    always @(negedge clock) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                mcpb  = (i == 0) ? CPB0 : CPB1;
                mflen = 1 + 10 * mcpb;
                if (in_frame[i]) begin
                    mp = pos[i];
                    if (mp == 1) begin
                        chk("sb_nonempty", i, ((i == 0) ? q0.size() : q1.size()) > 0, 1);
                        if (i == 0 && q0.size() > 0) cur[i] = q0.pop_front();
                        else if (i == 1 && q1.size() > 0) cur[i] = q1.pop_front();
                        last_b[i] = cur[i];
                        shifts[i] = 0;
                        e_tx = 1'b1;
                        e_sh = 1'b0;
                    end else begin
                        mq = (mp - 2) / mcpb;
                        mr = (mp - 2) % mcpb;
                        if (mq == 0) e_tx = 1'b0;
                        else if (mq <= 8) e_tx = cur[i][mq-1];
                        else e_tx = 1'b1;
                        e_sh = (mq >= 1 && mq <= 8 && mr == mcpb - 1);
                    end
                    chk("ready_busy", i, ready_o[i], 0);
                    chk("busy", i, busy_o[i], 1);
                    chk("tx_bit", i, tx_o[i], e_tx);
                    chk("load_n", i, ldn_o[i], (mp != 1));
                    chk("shift_right", i, sh_o[i], e_sh);
                    chk("done", i, done_o[i], (mp == mflen));
                    chk("load_val", i, lval_o[i], cur[i]);
                    if (sh_o[i] === 1'b1) shifts[i]++;
                    if (mp == mflen) chk("shift_count", i, shifts[i], 8);
                end else begin
                    chk("idle_ready", i, ready_o[i], 1);
                    chk("idle_busy", i, busy_o[i], 0);
                    chk("idle_tx", i, tx_o[i], 1);
                    chk("idle_load_n", i, ldn_o[i], 1);
                    chk("idle_shift", i, sh_o[i], 0);
                    chk("idle_done", i, done_o[i], 0);
                    chk("idle_load_val", i, lval_o[i], last_b[i]);
                end
                chk("no_shift_with_load", i, sh_o[i] & ~ldn_o[i], 0);
                chk("asr_zero", i, asr_o[i], 0);
                if (!rstn[i]) begin
                    in_frame[i] = 1'b0;
                    last_b[i]   = 8'h00;
                end else if (in_frame[i]) begin
                    if (pos[i] == mflen) in_frame[i] = 1'b0;
                    else pos[i] = pos[i] + 1;
                end else if (valid[i]) begin
                    in_frame[i] = 1'b1;
                    pos[i]      = 1;
                end
            end
        end
    end

    task automatic send(input int i, input logic [7:0] d, input bit keep);
        int guard = 0;
        @(posedge clock); #1;
        valid[i] = 1'b1;
        din[i]   = d;
        @(negedge clock);
        while (ready_o[i] !== 1'b1 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        chk("send_timeout", i, guard < 200, 1);
        if (guard < 200) begin
            if (i == 0) q0.push_back(d);
            else q1.push_back(d);
        end
        @(posedge clock); #1;
        if (!keep) valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int guard = 0;
        @(negedge clock);
        while (busy_o[i] !== 1'b0 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        chk("idle_timeout", i, guard < 200, 1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rstn[i] = 1'b0; valid[i] = 1'b0; din[i] = 8'h00;
            in_frame[i] = 1'b0; pos[i] = 0; shifts[i] = 0; cur[i] = 8'h00; last_b[i] = 8'h00;
        end
        repeat (2) @(posedge clock);
        #1;
        chk_on = 1'b1;
        @(posedge clock); #1;
        rstn[0] = 1'b1; rstn[1] = 1'b1;

        send(0, 8'hA5, 1'b0);
        wait_idle(0);

        send(0, 8'h3C, 1'b1);
        send(0, 8'hFF, 1'b0);
        wait_idle(0);

        send(0, 8'h81, 1'b0);
        @(posedge clock); #1;
        valid[0] = 1'b1; din[0] = 8'h00;
        @(posedge clock); #1;
        valid[0] = 1'b0;
        wait_idle(0);

        send(0, 8'h5A, 1'b0);
        repeat (18) @(posedge clock);
        #1;
        rstn[0] = 1'b0;
        @(posedge clock); #1;
        rstn[0] = 1'b1;
        repeat (3) @(posedge clock);

        send(1, 8'h01, 1'b0);
        wait_idle(1);

        for (int k = 0; k < 12; k++) begin
            send(0, 8'($urandom), 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clock);
        end
        wait_idle(0);
        for (int k = 0; k < 12; k++) begin
            send(1, 8'($urandom), ($urandom_range(0, 1) == 1));
            repeat ($urandom_range(0, 2)) @(posedge clock);
        end
        @(posedge clock); #1;
        valid[1] = 1'b0;
        wait_idle(1);
        repeat (4) @(posedge clock);

        chk("q0_drained", 0, q0.size(), 0);
        chk("q1_drained", 1, q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_tx_ctrl.md
SHIFT_TX_CTRL -- requirements
Module: shift_tx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit period; legal range 1..65535.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 data_in  input  8  byte to transmit; sampled on the accept edge.
REQ-005 data_valid  input  1  upstream offers data_in.
REQ-006 data_ready  output  1  block accepts a byte; accept = data_valid & data_ready at a rising edge.
REQ-007 load_val  output  8  parallel load value to the downstream 8-bit shift register.
REQ-008 load_n  output  1  active-low parallel-load command to the shift register.
REQ-009 shift_right  output  1  shift-right command to the shift register.
REQ-010 asr  output  1  arithmetic-shift select to the shift register; held 0 (logical shift).
REQ-011 q_lsb  input  1  shift register bit 0, returned from the shift register.
REQ-012 tx_bit  output  1  serial line; idle high.
REQ-013 busy  output  1  frame in progress (any state other than IDLE).
REQ-014 done  output  1  one-cycle pulse on the final cycle of a frame.

Function
REQ-015 States SHALL be IDLE, LOAD, START, DATA, STOP; one bit-period counter (0..CLKS_PER_BIT-1) and one bit index (0..7).
REQ-016 IDLE: data_ready=1, tx_bit=1, load_n=1, shift_right=0; accept moves to LOAD and registers data_in into load_val.
REQ-017 LOAD: exactly one cycle; load_n=0, shift_right=0, tx_bit=1; next state START.
REQ-018 START: tx_bit=0 for CLKS_PER_BIT cycles; next state DATA, bit index 0.
REQ-019 DATA: tx_bit=q_lsb; each bit lasts CLKS_PER_BIT cycles; shift_right=1 only on the last cycle of each bit period; after bit index 7 completes, next state STOP.
REQ-020 Exactly 8 shift_right pulses per frame; shift_right and load_n=0 SHALL never be asserted in the same cycle.
REQ-021 STOP: tx_bit=1 for CLKS_PER_BIT cycles; done=1 on the last STOP cycle; next state IDLE.
REQ-022 Frame length: accept edge to done cycle = 1 + 10*CLKS_PER_BIT cycles; data_ready reasserts the cycle after done.
REQ-023 data_ready=0 in every non-IDLE state; data_valid while busy is ignored and data_in is not sampled.
REQ-024 Upstream may hold data_valid high continuously; the next byte is accepted in the first IDLE cycle (back-to-back frames, one idle cycle between).
REQ-025 load_val SHALL hold its value from accept until the next accept.
REQ-026 CLKS_PER_BIT=1: every bit period is one cycle, shift_right is high for all 8 DATA cycles.
REQ-027 All outputs other than tx_bit in DATA SHALL be decoded from registered state only; tx_bit in DATA is combinational from q_lsb.

Reset
REQ-028 reset_n=0 at a rising edge forces IDLE, counter=0, bit index=0, load_val=8'h00 from any state, including mid-frame.
REQ-029 Outputs after a reset edge: data_ready=1, busy=0, done=0, tx_bit=1, load_n=1, shift_right=0, asr=0.
REQ-030 Reset mid-frame SHALL NOT produce a done pulse; no partial frame resumes.

Structure
REQ-031 Package shift_tx_pkg SHALL hold the state enumeration, DATA_BITS=8 and the counter width constant (16).
REQ-032 One sub-module, bit_timer: loadable down/up counter producing a last-cycle-of-period flag; instantiated once.

Verification
REQ-033 CLKS_PER_BIT=4, data_in=8'hA5 accepted at edge 0 -> load_n=0 cycle 1 with load_val=8'hA5; tx_bit = 0,1,0,1,0,0,1,0,1,1 each 4 cycles; 8 shift_right pulses; done on cycle 41.
REQ-034 data_valid held high with 8'h3C then 8'hFF -> second accept one cycle after first done; no byte lost or duplicated; second frame tx data bits all 1.
REQ-035 reset_n low during DATA bit 3 -> next cycle IDLE, tx_bit=1, data_ready=1, no done pulse.
REQ-036 data_valid pulsed with 8'h00 during START of an 8'h81 frame -> ignored; line shows 8'h81 frame only, load_val stays 8'h81.
REQ-037 CLKS_PER_BIT=1, data_in=8'h01 -> frame of 11 cycles from accept to done, shift_right high for 8 consecutive cycles, tx_bit data = 1,0,0,0,0,0,0,0.
REQ-038 Assertion on all runs: never (shift_right & ~load_n); asr always 0.
